// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART transmitter, with a start/finish watchdog
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_start,
  output logic [8:0]                 uart_data,
  input  logic                       uart_ready,
  input  logic                       uart_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       timeout_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
  state_t          state_q, state_d;
  logic [8:0]      uart_data_q, uart_data_d;
  logic [GW-1:0]   grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, sel;
  logic            lock_q, lock_d, timeout_err_q, timeout_err_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d, burst_inc;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            xfer, wd_hit;
  assign xfer         = |req_ready;
  assign wd_hit       = state_q != S_IDLE && wd_cnt_q == WW'(TIMEOUT_CYCLES - 1);
  assign burst_inc    = burst_cnt_q + BW'(1);
  assign uart_data    = uart_data_q;
  assign grant_id     = grant_id_q;
  assign grant_active = lock_q;
  assign timeout_err  = timeout_err_q;
  // candidate requester: the owner while locked, otherwise first valid at or above rr_ptr
  always_comb begin
    sel = lock_q ? grant_id_q : rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      logic [GW-1:0] idx;
      j = int'(rr_ptr_q) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      idx = GW'(j);
      if (!lock_q && req_valid[idx]) sel = idx;
    end
  end
  // next state: watchdog abort overrides normal frame progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = xfer ? S_START : S_IDLE;
      S_START: state_d = wd_hit ? S_IDLE : uart_busy ? S_WAIT : S_START;
      S_WAIT:  state_d = wd_hit || (uart_ready && !uart_busy) ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs: start held through S_START, single accept strobe only in S_IDLE
  always_comb begin
    uart_start = state_q == S_START;
    req_ready = '0;
    req_ready[sel] = !rst && uart_ready && state_q == S_IDLE && req_valid[sel];
  end
  // transfer capture, lock and burst accounting, watchdog counting
  always_comb begin
    uart_data_d   = xfer ? {1'b0, req_data[{sel, 3'b000} +: 8]} : uart_data_q;
    grant_id_d    = xfer ? sel : grant_id_q;
    rr_ptr_d      = xfer ? (sel == GW'(NUM_REQ - 1) ? '0 : sel + GW'(1)) : rr_ptr_q;
    lock_d        = xfer ? !req_last[sel] && burst_inc < BW'(MAX_BURST) : wd_hit ? 1'b0 : lock_q;
    burst_cnt_d   = xfer ? (lock_d ? burst_inc : '0) : wd_hit ? '0 : burst_cnt_q;
    wd_cnt_d      = state_d != state_q || state_q == S_IDLE ? '0 : wd_cnt_q + WW'(1);
    timeout_err_d = wd_hit;
  end
  // registers, cleared asynchronously so a mid-frame reset drops start at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      uart_data_q   <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      burst_cnt_q   <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      uart_data_q   <= uart_data_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      burst_cnt_q   <= burst_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table-driven check of the UART transmitter arbiter
module tb_uart_tx_arbiter;
  logic        clk = 0, rst = 1;
  logic [3:0]  req_valid = 0, req_last = 0, req_ready;
  logic [31:0] req_data = 0;
  logic        uart_start, uart_ready = 1, uart_busy = 0, grant_active, timeout_err;
  logic [8:0]  uart_data;
  logic [1:0]  grant_id;
  int          n_tests = 0, n_fail = 0;
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_gid;
    logic        exp_lock;
  } vec_t;
  vec_t vecs[22];
  localparam logic [31:0] D = 32'hD3C2B1A0;
  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_start(uart_start), .uart_data(uart_data),
    .uart_ready(uart_ready), .uart_busy(uart_busy), .grant_id(grant_id),
    .grant_active(grant_active), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_uart_start"}, uart_start, 0);
    chk({tag, "_uart_data"}, uart_data, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_grant_active"}, grant_active, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask
  task automatic frame();
    uart_ready = 0;
    uart_busy = 0;
    @(posedge clk); #1;
    chk("start_held", uart_start, 1);
    uart_busy = 1;
    @(posedge clk); #1;
    chk("start_drop", uart_start, 0);
    uart_busy = 0;
    uart_ready = 1;
    @(posedge clk); #1;
  endtask
  task automatic apply(input vec_t v, input bit run_frame);
    logic [8:0] exp_data;
    req_valid = v.valid;
    req_last = v.last;
    req_data = v.data;
    uart_ready = v.rdy;
    #1 chk("req_ready", req_ready, v.exp_ready);
    @(posedge clk); #1;
    exp_data = {1'b0, v.data[8*v.exp_gid +: 8]};
    chk("uart_start", uart_start, v.exp_ready != 0);
    if (v.exp_ready != 0) chk("uart_data", uart_data, exp_data);
    chk("grant_id", grant_id, v.exp_gid);
    chk("grant_active", grant_active, v.exp_lock);
    req_valid = 0;
    uart_ready = 1;
    if (v.exp_ready != 0 && run_frame) frame();
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int cnt;
    vecs[0]  = '{4'b1111, 4'b1111, D, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[1]  = '{4'b1111, 4'b1111, D, 1'b1, 4'b0010, 2'd1, 1'b0};
    vecs[2]  = '{4'b1111, 4'b1111, D, 1'b1, 4'b0100, 2'd2, 1'b0};
    vecs[3]  = '{4'b1111, 4'b1111, D, 1'b1, 4'b1000, 2'd3, 1'b0};
    vecs[4]  = '{4'b1111, 4'b1111, D, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1111, D, 1'b1, 4'b0010, 2'd1, 1'b0};
    vecs[6]  = '{4'b0100, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 2'd2, 1'b0};
    vecs[7]  = '{4'b1111, 4'b1111, D, 1'b1, 4'b1000, 2'd3, 1'b0};
    vecs[8]  = '{4'b1111, 4'b1111, D, 1'b0, 4'b0000, 2'd3, 1'b0};
    vecs[9]  = '{4'b0001, 4'b0001, D, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[10] = '{4'b1011, 4'b0000, D, 1'b1, 4'b0010, 2'd1, 1'b1};
    vecs[11] = '{4'b1001, 4'b0000, D, 1'b1, 4'b0000, 2'd1, 1'b1};
    vecs[12] = '{4'b1011, 4'b0000, D, 1'b1, 4'b0010, 2'd1, 1'b1};
    vecs[13] = '{4'b1011, 4'b0010, D, 1'b1, 4'b0010, 2'd1, 1'b0};
    vecs[14] = '{4'b1001, 4'b1001, D, 1'b1, 4'b1000, 2'd3, 1'b0};
    vecs[15] = '{4'b0011, 4'b0010, D, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[16] = '{4'b0011, 4'b0010, D, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[17] = '{4'b0011, 4'b0010, D, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[18] = '{4'b0011, 4'b0010, D, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[19] = '{4'b0011, 4'b0010, D, 1'b1, 4'b0010, 2'd1, 1'b0};
    vecs[20] = '{4'b0011, 4'b0010, D, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[21] = '{4'b0011, 4'b0010, D, 1'b1, 4'b0001, 2'd0, 1'b1};
    #3 chk_reset("reset");
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) apply(vecs[i], 1);
    apply('{4'b0011, 4'b0010, D, 1'b1, 4'b0001, 2'd0, 1'b1}, 0);
    cnt = 0;
    while (uart_start && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("wd_start_cycles", cnt, 50);
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_lock_clear", grant_active, 0);
    @(posedge clk); #1;
    chk("wd_pulse_len", timeout_err, 0);
    apply('{4'b0011, 4'b0011, D, 1'b1, 4'b0010, 2'd1, 1'b0}, 1);
    apply('{4'b1111, 4'b1111, D, 1'b1, 4'b0100, 2'd2, 1'b0}, 0);
    uart_ready = 0;
    @(posedge clk); #1;
    uart_busy = 1;
    @(posedge clk); #1;
    chk("mid_wait_start", uart_start, 0);
    chk("mid_wait_data", uart_data, 9'h0C2);
    uart_busy = 0;
    uart_ready = 1;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    #2 rst = 1;
    #1 chk_reset("midrst");
    @(posedge clk); #1;
    chk_reset("midrst_hold");
    req_valid = 0;
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    apply('{4'b1111, 4'b1111, D, 1'b1, 4'b0001, 2'd0, 1'b0}, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter (8 data bits, 2 stop bits, baud-tick-sampled start) between NUM_REQ byte-stream requesters. Round-robin arbitration happens at packet granularity: a requester that wins keeps the transmitter until it marks a byte `last` or hits the burst limit. The block drives the transmitter's start/data inputs and watches its ready/busy outputs. A watchdog recovers from a transmitter that never starts or never finishes.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 16, maximum bytes per grant before a forced release (≥1)
- TIMEOUT_CYCLES, 1_000_000, clk cycles allowed in S_START or S_WAIT before abort (≥2)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  requester i has a byte on req_data[8i+7:8i]
- req_data  in  8*NUM_REQ  packed request bytes
- req_last  in  NUM_REQ  byte is the final byte of requester i's packet
- req_ready  out  NUM_REQ  accept strobe, one-hot or zero
- uart_start  out  1  start request to the transmitter
- uart_data  out  9  {1'b0, byte} to the transmitter
- uart_ready  in  1  transmitter idle
- uart_busy  in  1  transmitter frame in progress
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner
- grant_active  out  1  a lock is held
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- States: S_IDLE, S_START, S_WAIT.
- **S_IDLE**
  - When uart_ready=1, compute sel:
    - If locked, sel = grant_id.
    - Otherwise, sel is the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[sel] = uart_ready && req_valid[sel] && state==S_IDLE. All other bits are 0. req_ready is combinational and is forced to 0 while rst=1.
  - Transfer occurs on the edge where req_valid[i] && req_ready[i]. On that edge:
    - Latch uart_data ← {0, byte}.
    - grant_id ← sel, rr_ptr ← sel+1 mod NUM_REQ.
    - burst_cnt increments.
    - Go to S_START.
- **Lock rules**
  - On transfer, if req_last=0 and burst_cnt+1 < MAX_BURST: lock=1 (grant_active=1).
  - Otherwise: lock=0 and burst_cnt ← 0.
  - While locked, only grant_id is served. If it drops req_valid, the block waits; no other requester is granted.
- **S_START**
  - uart_start=1 and uart_data is held stable. Start is held across baud ticks, because the transmitter samples start only on its tick.
  - Leave for S_WAIT on the first cycle with uart_busy=1.
- **S_WAIT**
  - uart_start=0.
  - Return to S_IDLE on the first cycle with uart_ready=1 && uart_busy=0.
- **Watchdog**
  - wd_cnt clears on every state change.
  - wd_cnt counts in S_START and S_WAIT.
  - At wd_cnt == TIMEOUT_CYCLES-1:
    - Pulse timeout_err for 1 cycle.
    - Drop uart_start, clear lock and burst_cnt.
    - Go to S_IDLE. The byte is discarded, not retried.
- **Width rules**
  - burst_cnt is $clog2(MAX_BURST+1) bits and never wraps past MAX_BURST.
  - rr_ptr wraps NUM_REQ-1 → 0.

## Timing
- Reset values:
  - uart_start=0, uart_data=0
  - grant_id=0, grant_active=0
  - timeout_err=0, req_ready=0
  - state S_IDLE, rr_ptr=0, burst_cnt=0, wd_cnt=0
- Reset mid-frame aborts immediately. uart_start deasserts asynchronously and no byte is retried.
- Latency: transfer at edge k puts uart_start=1 and the new uart_data from cycle k+1. uart_start drops the cycle after uart_busy is first seen high.
- At most one byte is accepted per frame. The earliest next accept is the cycle after uart_ready returns high in S_IDLE.
- Simultaneous requests with no lock: lowest index at or above rr_ptr wins.
- uart_ready=0 in S_IDLE means no accept and req_ready is all zero.
- uart_busy and uart_ready both high in S_START: treat as busy and move to S_WAIT.
- Forced release at MAX_BURST: the next grant follows round-robin from owner+1, even if the owner's packet is unfinished.

## Test plan
- **Single byte:** req 2 sends 0xA5 with last=1 and a model transmitter.
  - req_ready[2] strobes once.
  - uart_data=0x0A5 with start held until busy.
  - grant_active stays 0 and rr_ptr becomes 3.
- **Fairness:** all 4 requesters continuously valid, every byte last=1.
  - Grants run 0,1,2,3,0,1 with no requester skipped.
- **Packet lock:** req 1 sends 3 bytes (last on the 3rd) while req 0 and req 3 are valid.
  - All 3 bytes come from req 1 back-to-back, then req 3 wins (rr_ptr=2 → first valid ≥2 is 3).
- **Burst limit:** MAX_BURST=4, req 0 sends 6 bytes with last=0 and req 1 is valid.
  - After 4 bytes the lock releases, req 1 is granted, and req 0 resumes afterwards.
- **Watchdog:** TIMEOUT_CYCLES=50 and uart_busy held 0.
  - uart_start stays high for exactly 50 cycles, then timeout_err pulses 1 cycle, lock clears, and state returns to S_IDLE.
- **Reset mid-frame:** assert rst in S_WAIT.
  - All outputs return to reset values in the same cycle.
  - After release, the next grant starts from requester 0.
